// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO output path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pio_pkg;

    localparam int PIO_DATA_W = 32;

    // One operation is issued per cycle by the PIO state machine.
    typedef enum logic [1:0] {
        NOP     = 2'd0,
        OUT     = 2'd1,
        PULL    = 2'd2,
        MOV_DST = 2'd3
    } op_t;

endpackage

// File: rtl/pio_barrel_shift.sv
// Barrel shifter: extracts n bits from one end of a word and shifts the remainder away.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is committed.
module pio_barrel_shift #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              dir,
    input  logic [CNT_W-1:0]  n,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] shifted,
    output logic [DATA_W-1:0] bits
);

    logic [DATA_W-1:0] low_mask;
    logic [CNT_W-1:0]  left_pos;

    // n ranges 1..DATA_W; a shift by DATA_W clears the word in both directions.
    assign low_mask = ~({DATA_W{1'b1}} << n);
    assign left_pos = CNT_W'(DATA_W) - n;

    // Right: take the low n bits. Left: take the top n bits, right-justified.
    always_comb begin
        shifted = '0;
        bits    = '0;
        if (dir) begin
            shifted = (n >= CNT_W'(DATA_W)) ? '0 : (word >> n);
            bits    = word & low_mask;
        end else begin
            shifted = (n >= CNT_W'(DATA_W)) ? '0 : (word << n);
            bits    = word >> left_pos;
        end
    end

endmodule

// File: rtl/pio_output_shifter.sv
// PIO output shift register: OUT/PULL/MOV into the OSR with autopull from the TX FIFO.
// Latency: data_out/out_valid one cycle after an OUT; stall/fifo_pop combinational.
// Backpressure: stall asks the issuer to repeat the op; pops only when fifo_valid is high.
module pio_output_shifter
    import pio_pkg::*;
#(
    parameter int DATA_W = PIO_DATA_W,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  op_t               op,
    input  logic [CNT_W-2:0]  shift_cnt,
    input  logic [CNT_W-2:0]  pull_thresh,
    input  logic              shiftdir,
    input  logic              autopull,
    input  logic              pull_block,
    input  logic [DATA_W-1:0] mov_in,
    output logic [DATA_W-1:0] mov_out,
    input  logic              fifo_valid,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  shift_count
);

    logic [DATA_W-1:0] osr;
    logic [CNT_W-1:0]  count;

    logic [CNT_W-1:0]  n_eff;
    logic [CNT_W-1:0]  thr;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_after_out;
    logic              osr_drained;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] bits;

    logic [DATA_W-1:0] nxt_osr;
    logic [CNT_W-1:0]  nxt_count;
    logic              do_out;
    logic              pop_c;
    logic              stall_c;

    // A zero field encodes a full word for both the shift length and the threshold.
    assign n_eff = (shift_cnt == '0)   ? CNT_W'(DATA_W) : {1'b0, shift_cnt};
    assign thr   = (pull_thresh == '0) ? CNT_W'(DATA_W) : {1'b0, pull_thresh};

    // One extra bit so count+n never wraps before saturating at DATA_W.
    assign cnt_sum       = {1'b0, count} + {1'b0, n_eff};
    assign cnt_after_out = (cnt_sum > (CNT_W+1)'(DATA_W)) ? CNT_W'(DATA_W) : cnt_sum[CNT_W-1:0];
    assign osr_drained   = autopull && (count >= thr);

    pio_barrel_shift #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shift (
        .dir     (shiftdir),
        .n       (n_eff),
        .word    (osr),
        .shifted (shifted),
        .bits    (bits)
    );

    // Decode the issued op into next OSR/count, pop and stall.
    always_comb begin
        nxt_osr   = osr;
        nxt_count = count;
        do_out    = 1'b0;
        pop_c     = 1'b0;
        stall_c   = 1'b0;
        unique case (op)
            OUT: begin
                if (osr_drained) begin
                    // Refill first; the OUT is repeated once fresh data is in the OSR.
                    stall_c = 1'b1;
                    if (fifo_valid) begin
                        nxt_osr   = fifo_data;
                        nxt_count = '0;
                        pop_c     = 1'b1;
                    end
                end else begin
                    do_out    = 1'b1;
                    nxt_osr   = shifted;
                    nxt_count = cnt_after_out;
                    if (autopull && (cnt_after_out >= thr) && fifo_valid) begin
                        nxt_osr   = fifo_data;
                        nxt_count = '0;
                        pop_c     = 1'b1;
                    end
                end
            end
            PULL: begin
                // With autopull on, a PULL before the threshold is ignored.
                if (!(autopull && (count < thr))) begin
                    if (fifo_valid) begin
                        nxt_osr   = fifo_data;
                        nxt_count = '0;
                        pop_c     = 1'b1;
                    end else if (pull_block) begin
                        stall_c = 1'b1;
                    end else begin
                        nxt_osr   = mov_in;
                        nxt_count = '0;
                    end
                end
            end
            MOV_DST: begin
                nxt_osr   = mov_in;
                nxt_count = '0;
            end
            default: begin
                // Idle cycles are used to top up a drained OSR.
                if (osr_drained && fifo_valid) begin
                    nxt_osr   = fifo_data;
                    nxt_count = '0;
                    pop_c     = 1'b1;
                end
            end
        endcase
    end

    // Strobes are gated by reset so a held op cannot pop or stall during reset.
    assign fifo_pop    = pop_c & rst;
    assign stall       = stall_c & rst;
    assign mov_out     = osr;
    assign shift_count = count;

    // OSR, counter and the registered OUT result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            osr       <= '0;
            count     <= CNT_W'(DATA_W);
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            osr       <= nxt_osr;
            count     <= nxt_count;
            out_valid <= do_out;
            if (do_out) begin
                data_out <= bits;
            end
        end
    end

endmodule
